// File: rtl/faculty_fighter_keys_pkg.sv
// Shared key codes and control bundle for the keyboard-driven fighter
// controls. Codes are USB HID usage IDs as delivered by the Nios II driver.
package faculty_fighter_keys_pkg;

  // No key pressed
  localparam logic [7:0] KEY_NONE        = 8'h00;

  // Player keys
  localparam logic [7:0] KEY_W           = 8'h1A;
  localparam logic [7:0] KEY_A           = 8'h04;
  localparam logic [7:0] KEY_D           = 8'h07;
  localparam logic [7:0] KEY_SPACE       = 8'h2C;

  // NPC keys
  localparam logic [7:0] KEY_UP_ARROW    = 8'h52;
  localparam logic [7:0] KEY_LEFT_ARROW  = 8'h50;
  localparam logic [7:0] KEY_RIGHT_ARROW = 8'h4F;
  localparam logic [7:0] KEY_ENTER       = 8'h28;

  // Per-fighter control bundle: three move levels and a shoot pulse
  typedef struct packed {
    logic up;
    logic left;
    logic right;
    logic shoot;
  } fighter_ctrl_t;

endpackage

// File: rtl/key_channel.sv
// One fighter's control channel. Decodes the qualified keycode into move
// levels that only change on frame ticks, and turns a press of the shoot
// key into a single-cycle pulse, rate-limited by a frame-counted cooldown.
// Holding the shoot key never repeats; a press during cooldown is dropped.
module key_channel
  import faculty_fighter_keys_pkg::*;
#(
  parameter logic [7:0]  UP_CODE         = KEY_W,
  parameter logic [7:0]  LEFT_CODE       = KEY_A,
  parameter logic [7:0]  RIGHT_CODE      = KEY_D,
  parameter logic [7:0]  SHOOT_CODE      = KEY_SPACE,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_tick,
  input  logic [7:0]    i_stable_key,
  output fighter_ctrl_t o_ctrl
);

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

  logic       w_dec_up;
  logic       w_dec_left;
  logic       w_dec_right;
  logic       w_is_s;
  logic       w_fire;
  logic       w_cool_zero;

  logic       r_up;
  logic       r_left;
  logic       r_right;
  logic       r_shoot;
  logic       r_prev_s;
  logic [7:0] r_cool;

  // Decode the qualified keycode; only one key is ever active at a time
  always_comb begin
    w_dec_up    = (i_stable_key == UP_CODE);
    w_dec_left  = (i_stable_key == LEFT_CODE);
    w_dec_right = (i_stable_key == RIGHT_CODE);
    w_is_s      = (i_stable_key == SHOOT_CODE);
  end

  assign w_cool_zero = (r_cool == 8'd0);

  // A shot needs a fresh press (rising edge of is_s) and an idle cooldown
  assign w_fire = w_is_s & ~r_prev_s & w_cool_zero;

  // Move levels: sampled from the decode on frame ticks, held otherwise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_up    <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else if (i_tick) begin
      r_up    <= w_dec_up;
      r_left  <= w_dec_left;
      r_right <= w_dec_right;
    end
  end

  // Press-edge history; reset to 1 so a key held through reset cannot
  // produce an edge on the very first cycle out of reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev_s <= 1'b1;
    end else begin
      r_prev_s <= w_is_s;
    end
  end

  // Registered one-cycle shoot pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shoot <= 1'b0;
    end else begin
      r_shoot <= w_fire;
    end
  end

  // Cooldown in frames: load on a shot (wins over a same-cycle tick),
  // otherwise count down on ticks and stop at zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cool <= 8'd0;
    end else if (w_fire) begin
      r_cool <= COOL_LOAD;
    end else if (i_tick && !w_cool_zero) begin
      r_cool <= r_cool - 8'd1;
    end
  end

  assign o_ctrl = {r_up, r_left, r_right, r_shoot};

endmodule

// File: rtl/keycode_decoder.sv
// Keyboard front end for the fighters. Qualifies the raw Nios keycode
// against glitches, derives a frame tick from VGA_VS, and feeds both the
// player and NPC control channels. frame_clk is synchronous to Clk, so it
// is registered once for edge detection and not synchronised further.
module keycode_decoder
  import faculty_fighter_keys_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       Player_Up,
  output logic       Player_Left,
  output logic       Player_Right,
  output logic       Player_Shoot,
  output logic       NPC_Up,
  output logic       NPC_Left,
  output logic       NPC_Right,
  output logic       NPC_Shoot
);

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [7:0]    r_kc_q;
  logic [7:0]    r_cnt;
  logic [7:0]    r_stable_key;
  logic          r_vs_q;

  logic          w_tick;
  logic          w_key_same;
  logic          w_load;
  fighter_ctrl_t w_player;
  fighter_ctrl_t w_npc;

  assign w_key_same = (keycode == r_kc_q);
  assign w_load     = (r_cnt == STABLE_LAST);
  assign w_tick     = frame_clk & ~r_vs_q;

  // Sample the keycode and count how long it has stayed unchanged,
  // saturating so a long hold does not wrap back into the load point
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_kc_q <= KEY_NONE;
      r_cnt  <= 8'd0;
    end else begin
      r_kc_q <= keycode;
      if (!w_key_same) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != STABLE_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Accept the sampled keycode once it has been steady long enough
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stable_key <= KEY_NONE;
    end else if (w_load) begin
      r_stable_key <= r_kc_q;
    end
  end

  // Previous VS level for rising-edge (frame tick) detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_q <= 1'b0;
    end else begin
      r_vs_q <= frame_clk;
    end
  end

  key_channel #(
    .UP_CODE         (KEY_W),
    .LEFT_CODE       (KEY_A),
    .RIGHT_CODE      (KEY_D),
    .SHOOT_CODE      (KEY_SPACE),
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
  ) u_player (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_tick       (w_tick),
    .i_stable_key (r_stable_key),
    .o_ctrl       (w_player)
  );

  key_channel #(
    .UP_CODE         (KEY_UP_ARROW),
    .LEFT_CODE       (KEY_LEFT_ARROW),
    .RIGHT_CODE      (KEY_RIGHT_ARROW),
    .SHOOT_CODE      (KEY_ENTER),
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
  ) u_npc (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_tick       (w_tick),
    .i_stable_key (r_stable_key),
    .o_ctrl       (w_npc)
  );

  assign Player_Up    = w_player.up;
  assign Player_Left  = w_player.left;
  assign Player_Right = w_player.right;
  assign Player_Shoot = w_player.shoot;
  assign NPC_Up       = w_npc.up;
  assign NPC_Left     = w_npc.left;
  assign NPC_Right    = w_npc.right;
  assign NPC_Shoot    = w_npc.shoot;

endmodule

// File: tb/tb_keycode_decoder.sv
// Bench for keycode_decoder: directed scenarios followed by randomized
// keycode / frame streams, every cycle compared against a reference model
// that works from the sample history and "ticks since last shot".
module tb_keycode_decoder;
  import faculty_fighter_keys_pkg::*;

  localparam int STABLE = 4;
  localparam int COOL   = 30;
  localparam int FL     = 8;   // bench frame length in Clk cycles

  // clock / reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       fc;
  logic [7:0] kc;
  logic       p_up, p_left, p_right, p_shoot;
  logic       n_up, n_left, n_right, n_shoot;

  always #5 clk = ~clk;

  keycode_decoder #(
    .STABLE_CYCLES   (STABLE),
    .COOLDOWN_FRAMES (COOL)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .frame_clk    (fc),
    .keycode      (kc),
    .Player_Up    (p_up),
    .Player_Left  (p_left),
    .Player_Right (p_right),
    .Player_Shoot (p_shoot),
    .NPC_Up       (n_up),
    .NPC_Left     (n_left),
    .NPC_Right    (n_right),
    .NPC_Shoot    (n_shoot)
  );

  // scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         p_shots = 0;
  int         n_shots = 0;
  int         up_seen = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0] c_up[2]    = '{KEY_W, KEY_UP_ARROW};
  logic [7:0] c_left[2]  = '{KEY_A, KEY_LEFT_ARROW};
  logic [7:0] c_right[2] = '{KEY_D, KEY_RIGHT_ARROW};
  logic [7:0] c_shoot[2] = '{KEY_SPACE, KEY_ENTER};

  logic [7:0] m_hist[$];    // keycode samples, oldest first
  logic [7:0] m_stable = 8'h00;
  logic       m_vs_prev = 1'b0;
  logic [2:0] m_move[2];
  logic       m_was_s[2];
  int         m_since[2];   // frame ticks since this fighter's last shot
  logic       m_shot[2];

  task automatic model_edge(input logic r, input logic [7:0] k, input logic f);
    logic       tick;
    logic [7:0] old;
    logic       is_s;
    logic       fire;
    logic       all_eq;
    int         sz;
    if (r) begin
      m_hist.delete();
      m_hist.push_back(8'h00);
      m_stable  = 8'h00;
      m_vs_prev = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_move[ch]  = 3'b000;
        m_was_s[ch] = 1'b1;
        m_since[ch] = COOL;
        m_shot[ch]  = 1'b0;
      end
    end else begin
      tick = f & ~m_vs_prev;
      old  = m_stable;
      for (int ch = 0; ch < 2; ch++) begin
        is_s = (old == c_shoot[ch]);
        fire = is_s && !m_was_s[ch] && (m_since[ch] >= COOL);
        if (tick)
          m_move[ch] = {old == c_up[ch], old == c_left[ch], old == c_right[ch]};
        if (fire)
          m_since[ch] = 0;
        else if (tick && m_since[ch] < COOL)
          m_since[ch] = m_since[ch] + 1;
        m_was_s[ch] = is_s;
        m_shot[ch]  = fire;
      end
      // a key is accepted once the last STABLE samples all agree
      sz = m_hist.size();
      if (sz >= STABLE) begin
        all_eq = 1'b1;
        for (int i = 0; i < STABLE; i++)
          if (m_hist[sz-1-i] != m_hist[sz-1]) all_eq = 1'b0;
        if (all_eq) m_stable = m_hist[sz-1];
      end
      m_hist.push_back(k);
      if (m_hist.size() > STABLE + 1) void'(m_hist.pop_front());
      m_vs_prev = f;
    end
    exp_q.push_back({m_move[0], m_shot[0], m_move[1], m_shot[1]});
  endtask

  // driver tasks
  task automatic step(input logic r, input logic [7:0] k, input logic f);
    logic [7:0] got;
    rst = r;
    kc  = k;
    fc  = f;
    @(posedge clk);
    #1;
    model_edge(r, k, f);
    got = {p_up, p_left, p_right, p_shoot, n_up, n_left, n_right, n_shoot};
    check("outs", got, exp_q.pop_front());
    p_shots += int'(p_shoot);
    n_shots += int'(n_shoot);
    if (p_up) up_seen++;
  endtask

  task automatic frames(input logic [7:0] k, input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < FL; i++)
        step(1'b0, k, i < FL / 2);
  endtask

  // random stimulus
  logic [7:0] rnd_keys[10] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h2C,
                               8'h50, 8'h4F, 8'h52, 8'h28, 8'h00};

  task automatic random_run(input int n_runs);
    int         rphase = 0;
    int         rperiod = 8;
    logic [7:0] k;
    int         len;
    logic       r;
    for (int n = 0; n < n_runs; n++) begin
      if ($urandom_range(0, 9) == 0) k = 8'($urandom_range(0, 255));
      else k = rnd_keys[$urandom_range(0, 9)];
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        rphase++;
        if (rphase >= rperiod) begin
          rphase  = 0;
          rperiod = $urandom_range(4, 12);
        end
        r = ($urandom_range(0, 299) == 0);
        step(r, k, rphase < rperiod / 2);
      end
    end
  endtask

  initial begin
    // reset state
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("reset_outs", {p_up, p_left, p_right, p_shoot, n_up, n_left, n_right, n_shoot}, 8'h00);

    // qualification and move hold
    frames(8'h00, 2);
    frames(KEY_A, 2);
    check("left_on", 8'(p_left), 8'd1);
    frames(8'h00, 1);
    check("left_hold", 8'(p_left), 8'd1);
    frames(8'h00, 1);
    check("left_off", 8'(p_left), 8'd0);

    // glitch shorter than STABLE is ignored
    up_seen = 0;
    for (int i = 0; i < STABLE - 1; i++) step(1'b0, KEY_W, 1'b0);
    frames(8'h00, 3);
    check("glitch_no_up", 8'(up_seen), 8'd0);

    // long hold gives exactly one single-cycle shot
    p_shots = 0;
    frames(KEY_SPACE, 100);
    check("single_shot", 8'(p_shots), 8'd1);
    frames(8'h00, 2);

    // NPC cooldown drop, player unaffected
    n_shots = 0;
    frames(KEY_ENTER, 2);
    check("npc_first", 8'(n_shots), 8'd1);
    frames(8'h00, 3);
    p_shots = 0;
    frames(KEY_SPACE, 2);
    check("player_indep", 8'(p_shots), 8'd1);
    frames(8'h00, 3);
    n_shots = 0;
    frames(KEY_ENTER, 2);
    check("npc_dropped", 8'(n_shots), 8'd0);
    frames(8'h00, 25);
    n_shots = 0;
    frames(KEY_ENTER, 2);
    check("npc_after_cool", 8'(n_shots), 8'd1);

    // shot coinciding with a frame tick: cooldown is fully loaded
    frames(8'h00, 3);
    p_shots = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, i < FL / 2);
    for (int i = 3; i < FL; i++) step(1'b0, KEY_SPACE, i < FL / 2);
    for (int i = 0; i < FL; i++) step(1'b0, KEY_SPACE, i < FL / 2);
    check("collide_fire", 8'(p_shots), 8'd1);
    frames(8'h00, 28);
    p_shots = 0;
    frames(KEY_SPACE, 1);
    check("collide_29", 8'(p_shots), 8'd0);
    frames(8'h00, 1);
    frames(KEY_SPACE, 1);
    check("collide_30", 8'(p_shots), 8'd1);

    // reset mid-hold aborts cooldown and forces re-qualification
    step(1'b1, KEY_SPACE, 1'b0);
    check("rst_mid_outs", {p_up, p_left, p_right, p_shoot, n_up, n_left, n_right, n_shoot}, 8'h00);
    p_shots = 0;
    for (int i = 0; i < STABLE - 1; i++) step(1'b0, KEY_SPACE, 1'b0);
    check("rst_no_shot", 8'(p_shots), 8'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, KEY_SPACE, 1'b0);
    check("rst_cool_abort", 8'(p_shots), 8'd1);

    // randomized streams against the model
    step(1'b1, 8'h00, 1'b0);
    random_run(400);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
